// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the write port of a sync FIFO, with watermark pause/resume flow control.
// Optional pause_cnt output (number of pauses) is built when FIFO_ARB_PAUSE_CNT_EN is defined.
module fifo_wr_arbiter #(
   parameter int NREQ    = 4,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 4,
   parameter int HIGH_WM = 5,
   parameter int LOW_WM  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*DATA_W-1:0]   data_in,
   output logic [NREQ-1:0]          grant,
   output logic                     wr_en,
   output logic [DATA_W-1:0]        fifo_data,
   input  logic [CNT_W-1:0]         fifo_words
`ifdef FIFO_ARB_PAUSE_CNT_EN
   ,
   output logic [15:0]              pause_cnt
`endif
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CNT_W-1:0] HIGH_C = CNT_W'(HIGH_WM);
   localparam logic [CNT_W-1:0] LOW_C  = CNT_W'(LOW_WM);
   localparam logic [PTR_W-1:0] LAST_C = PTR_W'(NREQ - 1);

   typedef enum logic [1:0] {ACTIVE, DRAIN_WAIT, PAUSED, RESUME_WAIT} state_e;

   state_e           state_q, state_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0] win;
   logic             found;
   logic             grant_ok;

   logic [NREQ-1:0][DATA_W-1:0] lane_data;

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign lane_data[g] = data_in[g*DATA_W +: DATA_W];
   end

   // Grants only in ACTIVE and below the watermark; reset masks everything combinationally.
   assign grant_ok = rst_n && (state_q == ACTIVE) && (fifo_words < HIGH_C);

   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      if (grant_ok) begin
         for (int off = 0; off < NREQ; off++) begin
            idx = (int'(rr_ptr_q) + off) % NREQ;
            if (!found && req[idx[PTR_W-1:0]]) begin
               found = 1'b1;
               win   = idx[PTR_W-1:0];
            end
         end
      end
   end

   always_comb begin
      grant = '0;
      if (found) grant[win] = 1'b1;
   end

   assign wr_en = |grant;

   always_comb begin
      fifo_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) fifo_data |= lane_data[i];
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (found) rr_ptr_d = (win == LAST_C) ? '0 : win + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACTIVE:      if (fifo_words >= HIGH_C) state_d = DRAIN_WAIT;
         DRAIN_WAIT:  state_d = PAUSED;
         PAUSED:      if (fifo_words <= LOW_C) state_d = RESUME_WAIT;
         RESUME_WAIT: state_d = ACTIVE;
         default:     state_d = ACTIVE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ACTIVE;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef FIFO_ARB_PAUSE_CNT_EN
   logic [15:0] pause_cnt_q, pause_cnt_d;

   always_comb begin
      pause_cnt_d = pause_cnt_q;
      if (state_q == ACTIVE && state_d == DRAIN_WAIT && pause_cnt_q != 16'hFFFF)
         pause_cnt_d = pause_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pause_cnt_q <= '0;
      else        pause_cnt_q <= pause_cnt_d;
   end

   assign pause_cnt = pause_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected grant/data queued at drive time,
// popped and compared on the falling edge.
module tb_fifo_wr_arbiter;
   localparam int NREQ = 4, DATA_W = 8, CNT_W = 4;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NREQ-1:0]        req = '0;
   logic [NREQ*DATA_W-1:0] data_in = '0;
   logic [NREQ-1:0]        grant;
   logic                   wr_en;
   logic [DATA_W-1:0]      fifo_data;
   logic [CNT_W-1:0]       fifo_words = '0;
`ifdef FIFO_ARB_PAUSE_CNT_EN
   logic [15:0]            pause_cnt;
`endif

   fifo_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .CNT_W(CNT_W), .HIGH_WM(5), .LOW_WM(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .grant(grant),
      .wr_en(wr_en), .fifo_data(fifo_data), .fifo_words(fifo_words)
`ifdef FIFO_ARB_PAUSE_CNT_EN
      , .pause_cnt(pause_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string             tag;
      logic [NREQ-1:0]   grant;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t       sb_q[$];
   int         n_chk = 0, n_err = 0;
   logic [3:0] salt = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Lane i carries {i+1, salt}; salt changes every cycle so stale data is caught.
   task automatic drive(input string tag, input logic [3:0] r, input logic [3:0] fw,
                        input logic [3:0] eg);
      exp_t e;
      salt       = salt + 4'd1;
      req        = r;
      fifo_words = fw;
      for (int i = 0; i < NREQ; i++) data_in[i*DATA_W +: DATA_W] = {4'(i + 1), salt};
      e.tag   = tag;
      e.grant = eg;
      e.data  = '0;
      for (int i = 0; i < NREQ; i++) if (eg[i]) e.data = data_in[i*DATA_W +: DATA_W];
      sb_q.push_back(e);
   endtask

   task automatic step(input string tag, input logic [3:0] r, input logic [3:0] fw,
                       input logic [3:0] eg);
      @(posedge clk);
      #1;
      drive(tag, r, fw, eg);
   endtask

   // Idle reset pulse; inputs parked so the release edge does nothing.
   task automatic rst_pulse();
      @(posedge clk);
      #2;
      req        = '0;
      fifo_words = '0;
      rst_n      = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({e.tag, ".grant"}, 32'(grant), 32'(e.grant));
         chk({e.tag, ".wr_en"}, 32'(wr_en), 32'(|e.grant));
         chk({e.tag, ".data"}, 32'(fifo_data), 32'(e.data));
      end
   end

   initial begin
      req        = 4'b1111;
      fifo_words = '0;
      for (int i = 0; i < NREQ; i++) data_in[i*DATA_W +: DATA_W] = 8'hA5;
      #2;
      chk("rst.grant", 32'(grant), 32'h0);
      chk("rst.wr_en", 32'(wr_en), 32'h0);
      chk("rst.data", 32'(fifo_data), 32'h0);
`ifdef FIFO_ARB_PAUSE_CNT_EN
      chk("rst.pcnt", 32'(pause_cnt), 32'h0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive("t1", 4'b0001, 4'd0, 4'b0001);

      // strict rotation from a fresh pointer
      rst_pulse();
      step("t2a", 4'b1111, 4'd0, 4'b0001);
      step("t2b", 4'b1111, 4'd0, 4'b0010);
      step("t2c", 4'b1111, 4'd0, 4'b0100);
      step("t2d", 4'b1111, 4'd0, 4'b1000);
      step("t2e", 4'b1111, 4'd0, 4'b0001);

      // watermark pause and resume, rr_ptr=1 on entry
      step("t3_fw3", 4'b1111, 4'd3, 4'b0010);
      step("t3_fw4", 4'b1111, 4'd4, 4'b0100);
      step("t3_fw5", 4'b1111, 4'd5, 4'b0000);
      step("t3_dw",  4'b1111, 4'd4, 4'b0000);
      step("t3_p3",  4'b1111, 4'd3, 4'b0000);
      step("t3_p2",  4'b1111, 4'd2, 4'b0000);
      step("t3_rw",  4'b1111, 4'd2, 4'b0000);
      step("t3_act", 4'b1111, 4'd2, 4'b1000);

      // sparse request with rr_ptr=2, then withdrawal during a wait state
      step("t4_set", 4'b0010, 4'd0, 4'b0010);
      step("t4_a",   4'b0101, 4'd0, 4'b0100);
      step("t4_b",   4'b0101, 4'd0, 4'b0001);
      step("t4_hi",  4'b0100, 4'd5, 4'b0000);
      step("t4_dw",  4'b0100, 4'd1, 4'b0000);
      step("t4_p",   4'b0100, 4'd1, 4'b0000);
      step("t4_rw",  4'b0001, 4'd1, 4'b0000);
      step("t4_act", 4'b0001, 4'd1, 4'b0001);

      // async reset while paused
      step("t5_hi", 4'b1111, 4'd5, 4'b0000);
      step("t5_dw", 4'b1111, 4'd5, 4'b0000);
      step("t5_p",  4'b1111, 4'd5, 4'b0000);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t5_mid.grant", 32'(grant), 32'h0);
      chk("t5_mid.wr_en", 32'(wr_en), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive("t5_rel", 4'b1111, 4'd0, 4'b0001);
      step("t5_nxt", 4'b1111, 4'd0, 4'b0010);

      // watermark applied in the first cycle out of reset
      rst_pulse();
      drive("t6_hi", 4'b1111, 4'd5, 4'b0000);
      step("t6_dw",  4'b1111, 4'd4, 4'b0000);
      step("t6_p",   4'b1111, 4'd2, 4'b0000);
      step("t6_rw",  4'b1111, 4'd2, 4'b0000);
      step("t6_act", 4'b1111, 4'd2, 4'b0001);

`ifdef FIFO_ARB_PAUSE_CNT_EN
      rst_pulse();
      for (int k = 0; k < 3; k++) begin
         step("pc_hi", 4'b0000, 4'd5, 4'b0000);
         step("pc_dw", 4'b0000, 4'd0, 4'b0000);
         step("pc_p",  4'b0000, 4'd0, 4'b0000);
         step("pc_rw", 4'b0000, 4'd0, 4'b0000);
      end
      @(negedge clk);
      #1;
      chk("pcnt3", 32'(pause_cnt), 32'h3);
      force dut.pause_cnt_q = 16'hFFFF;
      #1;
      release dut.pause_cnt_q;
      step("ps_hi", 4'b0000, 4'd5, 4'b0000);
      step("ps_dw", 4'b0000, 4'd0, 4'b0000);
      @(negedge clk);
      #1;
      chk("pcnt_sat", 32'(pause_cnt), 32'hFFFF);
`endif

      repeat (2) @(negedge clk);
      #1;
      chk("sb_drain", 32'(sb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      n_err++;
      $display("FAIL timeout: got no finish expected finish before 100000");
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
